// File: rtl/ram1_ctrl_pkg.sv
// Shared definitions for the RAM1 data-memory initiator: state codes, lane
// constants and strobe enable levels.
package ram1_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int unsigned LANES = 4;

  localparam logic [3:0] SEL_FULL = 4'b1111;
  localparam logic [3:0] SEL_NONE = 4'b0000;

  // Strobe levels match the RamChipEnable/RamReadEnable/RamWriteEnable defines.
  localparam logic RAM_CE_ON  = 1'b1;
  localparam logic RAM_CE_OFF = 1'b0;
  localparam logic RAM_RE_ON  = 1'b1;
  localparam logic RAM_RE_OFF = 1'b0;
  localparam logic RAM_WE_ON  = 1'b1;
  localparam logic RAM_WE_OFF = 1'b0;

endpackage

// File: rtl/ram1_merge.sv
// Byte-lane merge for sub-word stores: selected lanes come from the store data,
// the rest from the word just read. Only instantiated when RAM1_RMW_EN is defined.
module ram1_merge
  import ram1_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] merged_o
);

  // Per-lane select between store data and read data.
  always_comb begin
    merged_o = rdata_i;
    for (int n = 0; n < int'(LANES); n++) begin
      if (sel_i[n]) begin
        merged_o[8*n +: 8] = wdata_i[8*n +: 8];
      end else begin
        merged_o[8*n +: 8] = rdata_i[8*n +: 8];
      end
    end
  end

endmodule

// File: rtl/ram1_ctrl.sv
// RAM1 bus initiator between the MEM stage and the RAM1 responder.
// Define RAM1_RMW_EN to build read-modify-write for sub-word stores.
module ram1_ctrl
  import ram1_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        ram_ce_o,
  output logic        ram_re_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic [29:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          accept_s;
  logic          phase_end_s;
  logic          addr_lo_unused;

`ifdef RAM1_RMW_EN
  logic [3:0]    sel_q;
  logic [31:0]   merged_s;

  ram1_merge u_merge (
    .rdata_i  (ram_rdata_i),
    .wdata_i  (wdata_q),
    .sel_i    (sel_q),
    .merged_o (merged_s)
  );
`endif

  // The RAM is word addressed, so the byte offset is dropped.
  assign addr_lo_unused = ^addr_i[1:0];
  assign accept_s       = (state_q == ST_IDLE) && req_i;
  assign phase_end_s    = (cnt_q == CNT_ZERO);

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          cnt_d = CNT_LOAD;
          if (we_i && (sel_i == SEL_NONE)) begin
            state_d = ST_DONE;
          end else if (!we_i) begin
            state_d = ST_READ;
`ifdef RAM1_RMW_EN
          end else if (sel_i != SEL_FULL) begin
            state_d = ST_READ;
`endif
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (phase_end_s) begin
          cnt_d   = CNT_LOAD;
          state_d = we_q ? ST_WRITE : ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_WRITE: begin
        if (phase_end_s) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand latches; read data (or the merged word) lands on the last READ edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      addr_q  <= 30'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
`ifdef RAM1_RMW_EN
      sel_q   <= 4'd0;
`endif
    end else if (accept_s) begin
      we_q    <= we_i;
      addr_q  <= addr_i[31:2];
      wdata_q <= wdata_i;
`ifdef RAM1_RMW_EN
      sel_q   <= sel_i;
`endif
    end else if ((state_q == ST_READ) && phase_end_s) begin
`ifdef RAM1_RMW_EN
      if (we_q) begin
        wdata_q <= merged_s;
      end else begin
        rdata_q <= ram_rdata_i;
      end
`else
      rdata_q <= ram_rdata_i;
`endif
    end
  end

  // Moore decode of the bus and pipeline outputs.
  always_comb begin
    ram_ce_o    = RAM_CE_OFF;
    ram_re_o    = RAM_RE_OFF;
    ram_we_o    = RAM_WE_OFF;
    ram_wdata_o = 32'd0;
    ack_o       = 1'b0;
    rdata_o     = 32'd0;
    case (state_q)
      ST_READ: begin
        ram_ce_o = RAM_CE_ON;
        ram_re_o = RAM_RE_ON;
      end
      ST_WRITE: begin
        ram_ce_o    = RAM_CE_ON;
        ram_we_o    = RAM_WE_ON;
        ram_wdata_o = wdata_q;
      end
      ST_DONE: begin
        ack_o   = 1'b1;
        rdata_o = we_q ? 32'd0 : rdata_q;
      end
      default: begin
        ack_o = 1'b0;
      end
    endcase
  end

  assign ram_addr_o = {2'b00, addr_q};
  // Gated by rst so the pipeline sees no stall while the block is held in reset.
  assign stall_o    = rst && (accept_s || (state_q == ST_READ) || (state_q == ST_WRITE));

endmodule
